// File: rtl/cmd_sequencer.sv
// Command word sequencer: decodes BANK/OUT words, issues bank writes
// and holds output commands until accepted downstream.
module cmd_sequencer #(
    parameter int ERR_CNT_W  = 16,
    parameter int CHECK_RSVD = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [31:0]          cmd_data,
    output logic                 bank_we,
    output logic [1:0]           bank_sel,
    output logic [7:0]           bank_wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           out_data,
    output logic                 busy,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        BANK,
        OUT
    } state_t;

    state_t     state;
    logic       live;
    logic [3:0] mask;
    logic [7:0] value;

    logic       accept;
    logic       id_bank;
    logic       id_out;
    logic       rsvd_bank;
    logic       rsvd_out;
    logic       bad;

    function automatic logic [1:0] lsb_idx(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        if (m[0])      idx = 2'd0;
        else if (m[1]) idx = 2'd1;
        else if (m[2]) idx = 2'd2;
        else if (m[3]) idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [3:0] clr_lsb(input logic [3:0] m);
        return m & (m - 4'd1);
    endfunction

    // live keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = (state == IDLE) && live;
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign id_bank   = (cmd_data[31:28] == 4'h0);
    assign id_out    = (cmd_data[31:28] == 4'h1);
    assign rsvd_bank = (CHECK_RSVD != 0) &&
                       ((|cmd_data[27:16]) || (|cmd_data[7:4]));
    assign rsvd_out  = (CHECK_RSVD != 0) && (|cmd_data[27:5]);
    assign bad       = !(id_bank && !rsvd_bank) &&
                       !(id_out && !rsvd_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            live       <= 1'b0;
            mask       <= 4'd0;
            value      <= 8'd0;
            bank_we    <= 1'b0;
            bank_sel   <= 2'd0;
            bank_wdata <= 8'd0;
            out_valid  <= 1'b0;
            out_data   <= 5'd0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            live      <= 1'b1;
            err_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad) begin
                            err_pulse <= 1'b1;
                            if (!(&err_count))
                                err_count <= err_count + ERR_CNT_W'(1);
                        end else if (id_bank) begin
                            if (cmd_data[3:0] != 4'd0) begin
                                state      <= BANK;
                                bank_we    <= 1'b1;
                                bank_sel   <= lsb_idx(cmd_data[3:0]);
                                bank_wdata <= cmd_data[15:8];
                                value      <= cmd_data[15:8];
                                mask       <= clr_lsb(cmd_data[3:0]);
                            end
                        end else begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out_data  <= cmd_data[4:0];
                        end
                    end
                end
                // first write was issued at accept; mask holds the rest
                BANK: begin
                    if (mask != 4'd0) begin
                        bank_we    <= 1'b1;
                        bank_sel   <= lsb_idx(mask);
                        bank_wdata <= value;
                        mask       <= clr_lsb(mask);
                    end else begin
                        bank_we <= 1'b0;
                        state   <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && accept)
            assert (!$isunknown(cmd_data))
            else $error("cmd_sequencer: X on cmd_data at accept");
    end
`endif

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 The block SHALL have parameter ERR_CNT_W, default 16, giving the width of the error counter (min 1).
REQ-002 The block SHALL have parameter CHECK_RSVD, default 1; 1 means nonzero reserved fields flag an error, 0 means reserved fields are ignored.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: upstream command word valid.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: command word accepted when cmd_valid && cmd_ready.
REQ-007 The block SHALL have port cmd_data, input, 32 bits: command word; ID [31:28].
REQ-008 The block SHALL have port bank_we, output, 1 bit: bank write strobe.
REQ-009 The block SHALL have port bank_sel, output, 2 bits: bank index of the current write.
REQ-010 The block SHALL have port bank_wdata, output, 8 bits: bank write data.
REQ-011 The block SHALL have port out_valid, output, 1 bit: output command valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data when out_valid && out_ready.
REQ-013 The block SHALL have port out_data, output, 5 bits: output command value.
REQ-014 The block SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE.
REQ-015 The block SHALL have port err_pulse, output, 1 bit: one-cycle pulse per rejected word.
REQ-016 The block SHALL have port err_count, output, ERR_CNT_W bits: saturating count of rejected words.

Function
REQ-017 The FSM SHALL have states IDLE, BANK and OUT; cmd_ready SHALL equal (state==IDLE).
REQ-018 A BANK word SHALL be decoded as: ID 4'b0000, enable mask [3:0], reserved [7:4], value [15:8], reserved [27:16].
REQ-019 An OUT word SHALL be decoded as: ID 4'b0001, out [4:0], reserved [27:5].
REQ-020 A word SHALL be rejected if its ID is not 0 or 1, or if CHECK_RSVD=1 and any reserved bit is 1; rejection has no other side effect.
REQ-021 On rejection, err_pulse SHALL be high for exactly the cycle after acceptance and the FSM SHALL stay in IDLE.
REQ-022 On rejection, err_count SHALL increment, holding at all-ones.
REQ-023 For a valid BANK word with mask 0, the word SHALL be accepted as a no-op, the FSM SHALL stay in IDLE, and no bank_we SHALL be issued.
REQ-024 For a valid BANK word with nonzero mask, the FSM SHALL enter BANK, latching the mask and value.
REQ-025 In BANK, one write per cycle SHALL be issued for each set mask bit in ascending index order: bank_we=1, bank_sel=index, bank_wdata=value.
REQ-026 The first write of a BANK word SHALL appear in the cycle immediately after acceptance.
REQ-027 Writes within a BANK word SHALL be contiguous cycles with no gaps.
REQ-028 The FSM SHALL return to IDLE in the cycle after the last write, so a mask with N set bits costs N busy cycles.
REQ-029 For a valid OUT word, the FSM SHALL enter OUT; from the next cycle out_valid=1 and out_data=out field, held stable until out_ready.
REQ-030 On the out_valid && out_ready edge, the FSM SHALL return to IDLE and out_valid SHALL drop the following cycle.
REQ-031 Back-to-back operation: a new word SHALL be accepted in the first IDLE cycle after a command completes.
REQ-032 bank_we SHALL be 0 outside BANK; bank_sel and bank_wdata SHALL hold their last values when bank_we=0.
REQ-033 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output except cmd_ready derived from state.
REQ-034 A word accepted while cmd_data is X SHALL NOT occur under protocol; if it does, behaviour is don't-care in simulation and the word SHALL be flagged by assertion.

Reset
REQ-035 While rst_n=0, the FSM SHALL be in IDLE.
REQ-036 While rst_n=0, these outputs SHALL be 0: cmd_ready, bank_we, bank_sel, bank_wdata, out_valid, out_data, busy, err_pulse, err_count, and the latched mask.
REQ-037 After release, cmd_ready SHALL rise in the first clk cycle following the deasserting edge.
REQ-038 Reset asserted mid-BANK or mid-OUT SHALL abort immediately: pending writes are dropped, out_valid deasserts asynchronously, and no partial state is retained.

Verification
REQ-039 A bench SHALL cover: BANK mask 4'b1010, value 8'hA5 -> writes bank_sel=1 then 3, data 8'hA5, in cycles 1 and 2 after accept; busy for 2 cycles; cmd_ready high in cycle 3.
REQ-040 A bench SHALL cover: BANK mask 4'b1111, value 8'h3C, then OUT 5'd17 back-to-back -> four writes sel 0,1,2,3, then out_data=17 valid; with out_ready held low 5 cycles, out_data stays stable and cmd_ready stays 0.
REQ-041 A bench SHALL cover: word 32'h2000_0000 and BANK word with bit 5 set (CHECK_RSVD=1) -> err_pulse twice, err_count=2, no bank_we, no out_valid; the same reserved-bit word with CHECK_RSVD=0 -> executed normally.
REQ-042 A bench SHALL cover: ERR_CNT_W=2 with 5 rejected words -> err_count sequence 1,2,3,3,3.
REQ-043 A bench SHALL cover: BANK mask 4'b0000 -> no writes, busy stays 0, next word accepted the cycle after.
REQ-044 A bench SHALL cover: rst_n pulled low during the second write of mask 4'b0111 -> bank_we 0 immediately, no third write after release, all outputs at reset values.
